// File: rtl/dual_issue_queue.sv
// Decoded-instruction FIFO that accepts up to two entries per cycle and
// presents the oldest one or two for issue to pipe A (any type) and pipe B (ALU only).
module dual_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [4:0]             in_rd_0,
  input  logic [4:0]             in_rd_1,
  input  logic                   in_we_0,
  input  logic                   in_we_1,
  input  logic [4:0]             in_rs1_0,
  input  logic [4:0]             in_rs1_1,
  input  logic [4:0]             in_rs2_0,
  input  logic [4:0]             in_rs2_1,
  input  logic [9:0]             in_type_0,
  input  logic [9:0]             in_type_1,
  input  logic                   in_br_0,
  input  logic                   in_br_1,
  input  logic [PAYLOAD_W-1:0]   in_payload_0,
  input  logic [PAYLOAD_W-1:0]   in_payload_1,
  output logic                   in_ready,
  output logic [1:0]             iss_valid,
  output logic [PAYLOAD_W-1:0]   iss_payload_a,
  output logic [PAYLOAD_W-1:0]   iss_payload_b,
  input  logic                   iss_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            dual_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0] TYPE_ALU = 10'h001;

  typedef struct packed {
    logic [4:0]           rd;
    logic                 we;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [9:0]           ty;
    logic                 br;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] head_nx, wr1_idx;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   dual_cnt_q, dual_cnt_d;
  logic [1:0]    n_enq, n_iss;
  logic          raw, waw, pair_ok;
  entry_t        ent_a, ent_b;

  assign head_nx  = head_q + AW'(1);
  assign ent_a    = mem_q[head_q];
  assign ent_b    = mem_q[head_nx];
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;
  assign dual_cnt = dual_cnt_q;

  // Pairing rules: r0 writes never create hazards; branches only ever issue in pipe A.
  assign raw = ent_a.we && (ent_a.rd != '0) &&
               ((ent_b.rs1 == ent_a.rd) || (ent_b.rs2 == ent_a.rd));
  assign waw = ent_a.we && ent_b.we && (ent_a.rd == ent_b.rd) && (ent_a.rd != '0);
  assign pair_ok = !raw && !waw && !ent_a.br && (ent_b.ty == TYPE_ALU) && !ent_b.br;

  assign iss_valid[0]  = (count_q != '0);
  assign iss_valid[1]  = (count_q >= CW'(2)) && pair_ok;
  assign iss_payload_a = ent_a.payload;
  assign iss_payload_b = ent_b.payload;

  assign n_enq   = in_ready ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;
  assign n_iss   = iss_ready ? ({1'b0, iss_valid[0]} + {1'b0, iss_valid[1]}) : 2'd0;
  // A lone slot-1 instruction is compacted down to the tail position.
  assign wr1_idx = tail_q + AW'(in_valid[0]);

  always_ff @(posedge clk) begin
    if (in_ready && !flush) begin
      if (in_valid[0])
        mem_q[tail_q] <= '{in_rd_0, in_we_0, in_rs1_0, in_rs2_0, in_type_0, in_br_0, in_payload_0};
      if (in_valid[1])
        mem_q[wr1_idx] <= '{in_rd_1, in_we_1, in_rs1_1, in_rs2_1, in_type_1, in_br_1, in_payload_1};
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    dual_cnt_d = dual_cnt_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(n_iss);
      tail_d  = tail_q + AW'(n_enq);
      count_d = count_q + CW'(n_enq) - CW'(n_iss);
      if (iss_ready && (iss_valid == 2'b11))
        dual_cnt_d = dual_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dual_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      dual_cnt_q <= dual_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (iss_valid != 2'b10);
      assert (count_q <= CW'(DEPTH));
    end
  end
endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: table of single-cycle vectors plus
// hand-written fill/wrap, flush and asynchronous-reset sequences.
module tb_dual_issue_queue;
  localparam int DEPTH = 8;
  localparam int PW    = 128;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [9:0]  ty;
    logic        br;
    logic [31:0] pl;
  } ins_t;

  typedef struct packed {
    logic [1:0]  v;
    ins_t        i0;
    ins_t        i1;
    logic [1:0]  eiv;
    logic [31:0] ecnt;
    logic [31:0] edual;
    logic [31:0] epa;
    logic [31:0] epb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [1:0]    in_valid = 2'b00;
  logic [4:0]    in_rd_0 = '0, in_rd_1 = '0, in_rs1_0 = '0, in_rs1_1 = '0, in_rs2_0 = '0, in_rs2_1 = '0;
  logic          in_we_0 = 1'b0, in_we_1 = 1'b0, in_br_0 = 1'b0, in_br_1 = 1'b0;
  logic [9:0]    in_type_0 = '0, in_type_1 = '0;
  logic [PW-1:0] in_payload_0 = '0, in_payload_1 = '0;
  logic          in_ready;
  logic [1:0]    iss_valid;
  logic [PW-1:0] iss_payload_a, iss_payload_b;
  logic          iss_ready = 1'b0;
  logic [3:0]    count;
  logic [31:0]   dual_cnt;

  int n_vec = 0;
  int n_miss = 0;
  int seq = 0, m_head = 0, m_cnt = 0, m_dual = 0;
  vec_t tbl [30];
  ins_t nop;

  always #5 clk = ~clk;

  dual_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_rd_0(in_rd_0), .in_rd_1(in_rd_1), .in_we_0(in_we_0), .in_we_1(in_we_1),
    .in_rs1_0(in_rs1_0), .in_rs1_1(in_rs1_1), .in_rs2_0(in_rs2_0), .in_rs2_1(in_rs2_1),
    .in_type_0(in_type_0), .in_type_1(in_type_1), .in_br_0(in_br_0), .in_br_1(in_br_1),
    .in_payload_0(in_payload_0), .in_payload_1(in_payload_1), .in_ready(in_ready),
    .iss_valid(iss_valid), .iss_payload_a(iss_payload_a), .iss_payload_b(iss_payload_b),
    .iss_ready(iss_ready), .count(count), .dual_cnt(dual_cnt)
  );

  function automatic ins_t ins(input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [9:0] ty, input logic br,
                               input logic [31:0] pl);
    ins_t r;
    r.rd = rd; r.we = we; r.rs1 = rs1; r.rs2 = rs2; r.ty = ty; r.br = br; r.pl = pl;
    return r;
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] pl);
    return ins(rd, 1'b1, rs1, rs2, 10'h001, 1'b0, pl);
  endfunction

  // Independent ALU instruction tagged with its sequence number.
  function automatic ins_t seqins(input int s);
    return alu(5'((s % 31) + 1), 5'd0, 5'd0, 32'(s));
  endfunction

  function automatic vec_t mkv(input logic [1:0] v, input ins_t a, input ins_t b,
                               input logic [1:0] eiv, input int ecnt, input int edual,
                               input int epa, input int epb);
    vec_t r;
    r.v = v; r.i0 = a; r.i1 = b; r.eiv = eiv;
    r.ecnt = ecnt; r.edual = edual; r.epa = epa; r.epb = epb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input ins_t a, input ins_t b, input logic ir);
    in_valid = v; iss_ready = ir;
    in_rd_0 = a.rd; in_we_0 = a.we; in_rs1_0 = a.rs1; in_rs2_0 = a.rs2;
    in_type_0 = a.ty; in_br_0 = a.br; in_payload_0 = PW'(a.pl);
    in_rd_1 = b.rd; in_we_1 = b.we; in_rs1_1 = b.rs1; in_rs2_1 = b.rs2;
    in_type_1 = b.ty; in_br_1 = b.br; in_payload_1 = PW'(b.pl);
  endtask

  // One cycle of all-ALU traffic against a sequence-number model; entered and left at negedge.
  task automatic cyc(input logic [1:0] v, input logic ir, input string tag);
    logic [1:0] eiv;
    logic       rdy;
    int         ne, ni;
    drive(v, seqins(seq), seqins(v[0] ? seq + 1 : seq), ir);
    #1;
    n_vec++;
    eiv = (m_cnt >= 2) ? 2'b11 : (m_cnt >= 1) ? 2'b01 : 2'b00;
    rdy = (m_cnt <= DEPTH - 2);
    chk({tag, " count"}, count, m_cnt);
    chk({tag, " iss_valid"}, iss_valid, eiv);
    chk({tag, " in_ready"}, in_ready, rdy);
    chk({tag, " dual_cnt"}, dual_cnt, m_dual);
    if (eiv[0]) chk({tag, " payload_a"}, iss_payload_a, m_head);
    if (eiv[1]) chk({tag, " payload_b"}, iss_payload_b, m_head + 1);
    @(posedge clk);
    ne = rdy ? (int'(v[0]) + int'(v[1])) : 0;
    ni = ir ? (int'(eiv[0]) + int'(eiv[1])) : 0;
    if (ir && eiv == 2'b11) m_dual++;
    m_cnt  = m_cnt + ne - ni;
    seq    = seq + ne;
    m_head = m_head + ni;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nop = '0;
    tbl[0]  = mkv(2'b00, nop, nop, 2'b00, 0, 0, 0, 0);
    tbl[1]  = mkv(2'b11, alu(1, 2, 3, 'h10), alu(4, 5, 6, 'h11), 2'b00, 0, 0, 0, 0);
    tbl[2]  = mkv(2'b00, nop, nop, 2'b11, 2, 0, 'h10, 'h11);
    tbl[3]  = mkv(2'b00, nop, nop, 2'b00, 0, 1, 0, 0);
    tbl[4]  = mkv(2'b11, alu(7, 1, 1, 'h20), alu(8, 7, 2, 'h21), 2'b00, 0, 1, 0, 0);
    tbl[5]  = mkv(2'b00, nop, nop, 2'b01, 2, 1, 'h20, 0);
    tbl[6]  = mkv(2'b00, nop, nop, 2'b01, 1, 1, 'h21, 0);
    tbl[7]  = mkv(2'b00, nop, nop, 2'b00, 0, 1, 0, 0);
    tbl[8]  = mkv(2'b11, alu(9, 1, 1, 'h30), ins(10, 1, 1, 1, 10'h002, 0, 'h31), 2'b00, 0, 1, 0, 0);
    tbl[9]  = mkv(2'b00, nop, nop, 2'b01, 2, 1, 'h30, 0);
    tbl[10] = mkv(2'b00, nop, nop, 2'b01, 1, 1, 'h31, 0);
    tbl[11] = mkv(2'b00, nop, nop, 2'b00, 0, 1, 0, 0);
    tbl[12] = mkv(2'b11, ins(0, 0, 1, 2, 10'h001, 1, 'h40), alu(11, 1, 1, 'h41), 2'b00, 0, 1, 0, 0);
    tbl[13] = mkv(2'b00, nop, nop, 2'b01, 2, 1, 'h40, 0);
    tbl[14] = mkv(2'b00, nop, nop, 2'b01, 1, 1, 'h41, 0);
    tbl[15] = mkv(2'b00, nop, nop, 2'b00, 0, 1, 0, 0);
    tbl[16] = mkv(2'b11, alu(0, 1, 1, 'h50), alu(12, 0, 0, 'h51), 2'b00, 0, 1, 0, 0);
    tbl[17] = mkv(2'b00, nop, nop, 2'b11, 2, 1, 'h50, 'h51);
    tbl[18] = mkv(2'b00, nop, nop, 2'b00, 0, 2, 0, 0);
    tbl[19] = mkv(2'b11, alu(13, 1, 1, 'h60), ins(14, 1, 2, 3, 10'h004, 0, 'h61), 2'b00, 0, 2, 0, 0);
    tbl[20] = mkv(2'b00, nop, nop, 2'b01, 2, 2, 'h60, 0);
    tbl[21] = mkv(2'b00, nop, nop, 2'b01, 1, 2, 'h61, 0);
    tbl[22] = mkv(2'b00, nop, nop, 2'b00, 0, 2, 0, 0);
    tbl[23] = mkv(2'b11, alu(15, 1, 1, 'h70), alu(15, 2, 2, 'h71), 2'b00, 0, 2, 0, 0);
    tbl[24] = mkv(2'b00, nop, nop, 2'b01, 2, 2, 'h70, 0);
    tbl[25] = mkv(2'b00, nop, nop, 2'b01, 1, 2, 'h71, 0);
    tbl[26] = mkv(2'b00, nop, nop, 2'b00, 0, 2, 0, 0);
    tbl[27] = mkv(2'b10, nop, alu(16, 1, 1, 'h80), 2'b00, 0, 2, 0, 0);
    tbl[28] = mkv(2'b00, nop, nop, 2'b01, 1, 2, 'h80, 0);
    tbl[29] = mkv(2'b00, nop, nop, 2'b00, 0, 2, 0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 30; k++) begin
      drive(tbl[k].v, tbl[k].i0, tbl[k].i1, 1'b1);
      #1;
      n_vec++;
      chk($sformatf("v%0d iss_valid", k), iss_valid, tbl[k].eiv);
      chk($sformatf("v%0d count", k), count, tbl[k].ecnt);
      chk($sformatf("v%0d in_ready", k), in_ready, 1'b1);
      chk($sformatf("v%0d dual_cnt", k), dual_cnt, tbl[k].edual);
      if (tbl[k].eiv[0]) chk($sformatf("v%0d payload_a", k), iss_payload_a, tbl[k].epa);
      if (tbl[k].eiv[1]) chk($sformatf("v%0d payload_b", k), iss_payload_b, tbl[k].epb);
      @(posedge clk);
      @(negedge clk);
    end

    // Fill to 7 with issue stalled, hold while full, then stream with wrap, then drain.
    m_cnt = 0; m_dual = 2; seq = 0; m_head = 0;
    cyc(2'b01, 1'b0, "fill");
    repeat (3) cyc(2'b11, 1'b0, "fill");
    repeat (2) cyc(2'b11, 1'b0, "full");
    repeat (20) cyc(2'b11, 1'b1, "wrap");
    repeat (4) cyc(2'b00, 1'b1, "drain");

    // Flush at count 5 with a simultaneous enqueue and a would-be dual issue.
    cyc(2'b01, 1'b0, "pre-flush");
    repeat (2) cyc(2'b11, 1'b0, "pre-flush");
    drive(2'b11, seqins(seq), seqins(seq + 1), 1'b1);
    flush = 1'b1;
    #1;
    n_vec++;
    chk("flush-cycle count", count, 5);
    chk("flush-cycle iss_valid", iss_valid, 2'b11);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    m_cnt = 0; m_head = seq;
    drive(2'b00, nop, nop, 1'b1);
    #1;
    n_vec++;
    chk("post-flush count", count, 0);
    chk("post-flush iss_valid", iss_valid, 2'b00);
    chk("post-flush dual_cnt", dual_cnt, m_dual);
    @(posedge clk);
    @(negedge clk);
    cyc(2'b00, 1'b1, "post-flush idle");

    // Asynchronous reset between clock edges with count 4.
    repeat (2) cyc(2'b11, 1'b0, "pre-reset");
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    chk("async-rst count", count, 0);
    chk("async-rst iss_valid", iss_valid, 2'b00);
    chk("async-rst in_ready", in_ready, 1'b1);
    chk("async-rst dual_cnt", dual_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_dual = 0; m_head = seq;
    cyc(2'b11, 1'b1, "post-reset");
    repeat (2) cyc(2'b00, 1'b1, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
